// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_arbiter_pkg : shared types and defaults for the RAM arbiter | rev 1.0
// ---------------------------------------------------------------------------
package ram_arbiter_pkg;

   localparam int ADDR_W_DEF = 22;
   localparam int DATA_W_DEF = 32;
   localparam int WEN_W      = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2 : combinational two-input round-robin picker | rev 1.0
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       mask,
   output logic       valid,
   output logic       sel
);

   logic [1:0] eff;

   // mask drops the requester named by last (the one being acked right now)
   always_comb begin
      eff = req;
      if (mask) begin
         eff[last] = 1'b0;
      end
      valid = |eff;
      sel   = (eff == 2'b11) ? ~last : eff[1];
   end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_arbiter : round-robin sharing of a single-port byte-write RAM | rev 1.0
// ---------------------------------------------------------------------------
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [WEN_W-1:0]  m0_wen,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [WEN_W-1:0]  m1_wen,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [WEN_W-1:0]  ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_t            state;
   logic              gnt;
   logic              last;
   logic              in_resp;
   logic              pick_valid;
   logic              pick_sel;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [WEN_W-1:0]  sel_wen;

   assign in_resp = (state == RESP);

   // In RESP the acked owner still holds req, so it is masked and treated as last
   rr_arb2 u_pick (
      .req   ({m1_req, m0_req}),
      .last  (in_resp ? gnt : last),
      .mask  (in_resp),
      .valid (pick_valid),
      .sel   (pick_sel)
   );

   assign sel_addr  = pick_sel ? m1_addr  : m0_addr;
   assign sel_wdata = pick_sel ? m1_wdata : m0_wdata;
   assign sel_wen   = pick_sel ? m1_wen   : m0_wen;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         last      <= 1'b1;
         ram_wen   <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  ram_addr  <= sel_addr;
                  ram_wdata <= sel_wdata;
                  ram_wen   <= sel_wen;
                  gnt       <= pick_sel;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               ram_wen <= '0;
               state   <= RESP;
            end
            RESP: begin
               last <= gnt;
               if (pick_valid) begin
                  ram_addr  <= sel_addr;
                  ram_wdata <= sel_wdata;
                  ram_wen   <= sel_wen;
                  gnt       <= pick_sel;
                  state     <= ACCESS;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               ram_wen <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

   // Ack follows state directly, so it remains visible even if rst rises in RESP
   assign m0_ack   = in_resp & ~gnt;
   assign m1_ack   = in_resp &  gnt;
   assign m0_rdata = m0_ack ? ram_rdata : '0;
   assign m1_rdata = m1_ack ? ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ram_arbiter : cycle-table and directed-sequence bench for ram_arbiter | rev 1.0
// ---------------------------------------------------------------------------
module tb_ram_arbiter;
   import ram_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m1_req;
   logic [21:0] m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic [3:0]  m0_wen, m1_wen;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic [3:0]  ram_wen;
   logic [21:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   logic [31:0] mem [16];
   logic        mem_clear;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_wen    (m0_wen),
      .m0_ack    (m0_ack),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_wen    (m1_wen),
      .m1_ack    (m1_ack),
      .m1_rdata  (m1_rdata),
      .ram_wen   (ram_wen),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // RAM model: registered read, read-before-write, byte lanes
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'hFFFF_FFFF;
         ram_rdata <= '0;
      end else begin
         ram_rdata <= mem[ram_addr[3:0]];
         for (int b = 0; b < 4; b++) begin
            if (ram_wen[b]) mem[ram_addr[3:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
         end
      end
   end

   typedef struct {
      logic        rst;
      logic        r0;
      logic [21:0] a0;
      logic [3:0]  w0;
      logic [31:0] d0;
      logic        r1;
      logic [21:0] a1;
      logic [3:0]  w1;
      logic [31:0] d1;
      logic [3:0]  ewen;
      logic [21:0] eaddr;
      logic        eack0;
      logic        eack1;
      logic [31:0] erd0;
      logic [31:0] erd1;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(
      input logic rs, input logic r0, input logic [21:0] a0, input logic [3:0] w0,
      input logic [31:0] d0, input logic r1, input logic [21:0] a1, input logic [3:0] w1,
      input logic [3:0] ewen, input logic [21:0] eaddr, input logic eack0,
      input logic eack1, input logic [31:0] erd0, input logic [31:0] erd1);
      vec_t v;
      v.rst = rs;  v.r0 = r0; v.a0 = a0; v.w0 = w0; v.d0 = d0;
      v.r1 = r1;   v.a1 = a1; v.w1 = w1; v.d1 = 32'h0;
      v.ewen = ewen; v.eaddr = eaddr; v.eack0 = eack0; v.eack1 = eack1;
      v.erd0 = erd0; v.erd1 = erd1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;  mem_clear = 1'b1;
      m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wen = '0;
      m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wen = '0;

      // Reset with both requesting, m0 halfword write, m1 read-back,
      // then continuous contention with alternating grants.
      tbl[0]  = mk(1, 1, 5, 4'h3, 32'h11223344, 1, 5, 0,  4'h0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 1, 5, 4'h3, 32'h11223344, 1, 5, 0,  4'h0, 0, 0, 0, 0, 0);
      tbl[2]  = mk(0, 1, 5, 4'h3, 32'h11223344, 1, 5, 0,  4'h0, 0, 0, 0, 0, 0);
      tbl[3]  = mk(0, 1, 5, 4'h3, 32'h11223344, 1, 5, 0,  4'h3, 5, 0, 0, 0, 0);
      tbl[4]  = mk(0, 1, 5, 4'h3, 32'h11223344, 1, 5, 0,  4'h0, 5, 1, 0, 32'hFFFFFFFF, 0);
      tbl[5]  = mk(0, 0, 5, 4'h3, 32'h11223344, 1, 5, 0,  4'h0, 5, 0, 0, 0, 0);
      tbl[6]  = mk(0, 0, 5, 4'h3, 32'h11223344, 1, 5, 0,  4'h0, 5, 0, 1, 0, 32'hFFFF3344);
      tbl[7]  = mk(0, 0, 5, 4'h3, 32'h11223344, 0, 5, 0,  4'h0, 5, 0, 0, 0, 0);
      tbl[8]  = mk(0, 1, 1, 4'hF, 32'hA0A0A0A0, 1, 2, 0,  4'h0, 5, 0, 0, 0, 0);
      tbl[9]  = mk(0, 1, 1, 4'hF, 32'hA0A0A0A0, 1, 2, 0,  4'hF, 1, 0, 0, 0, 0);
      tbl[10] = mk(0, 1, 1, 4'hF, 32'hA0A0A0A0, 1, 2, 0,  4'h0, 1, 1, 0, 32'hFFFFFFFF, 0);
      tbl[11] = mk(0, 1, 3, 4'hF, 32'hB3B3B3B3, 1, 2, 0,  4'h0, 2, 0, 0, 0, 0);
      tbl[12] = mk(0, 1, 3, 4'hF, 32'hB3B3B3B3, 1, 2, 0,  4'h0, 2, 0, 1, 0, 32'hFFFFFFFF);
      tbl[13] = mk(0, 1, 3, 4'hF, 32'hB3B3B3B3, 1, 1, 0,  4'hF, 3, 0, 0, 0, 0);
      tbl[14] = mk(0, 1, 3, 4'hF, 32'hB3B3B3B3, 1, 1, 0,  4'h0, 3, 1, 0, 32'hFFFFFFFF, 0);
      tbl[15] = mk(0, 0, 3, 4'hF, 32'hB3B3B3B3, 1, 1, 0,  4'h0, 1, 0, 0, 0, 0);
      tbl[16] = mk(0, 0, 3, 4'hF, 32'hB3B3B3B3, 1, 1, 0,  4'h0, 1, 0, 1, 0, 32'hA0A0A0A0);
      tbl[17] = mk(0, 0, 3, 4'hF, 32'hB3B3B3B3, 0, 1, 0,  4'h0, 1, 0, 0, 0, 0);

      step();
      mem_clear = 1'b0;
      for (int i = 0; i < 18; i++) begin
         if (i != 0) step();
         rst = tbl[i].rst;
         m0_req = tbl[i].r0; m0_addr = tbl[i].a0; m0_wen = tbl[i].w0; m0_wdata = tbl[i].d0;
         m1_req = tbl[i].r1; m1_addr = tbl[i].a1; m1_wen = tbl[i].w1; m1_wdata = tbl[i].d1;
         @(negedge clk);
         chk($sformatf("row%0d ram_wen", i),  32'(ram_wen),  32'(tbl[i].ewen));
         chk($sformatf("row%0d ram_addr", i), 32'(ram_addr), 32'(tbl[i].eaddr));
         chk($sformatf("row%0d m0_ack", i),   32'(m0_ack),   32'(tbl[i].eack0));
         chk($sformatf("row%0d m1_ack", i),   32'(m1_ack),   32'(tbl[i].eack1));
         chk($sformatf("row%0d m0_rdata", i), m0_rdata,      tbl[i].erd0);
         chk($sformatf("row%0d m1_rdata", i), m1_rdata,      tbl[i].erd1);
      end
      chk("mem5 halfword", mem[5], 32'hFFFF3344);
      chk("mem3 word",     mem[3], 32'hB3B3B3B3);

      // Reset in the ACCESS cycle of an m0 write: write lands, no ack
      step();
      m0_req = 1'b1; m0_addr = 22'd7; m0_wen = 4'hF; m0_wdata = 32'hDEADBEEF;
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("rstacc ram_wen", 32'(ram_wen), 32'hF);
      chk("rstacc ram_addr", 32'(ram_addr), 32'd7);
      step();
      rst = 1'b0; m0_req = 1'b0;
      @(negedge clk);
      chk("rstacc m0_ack", 32'(m0_ack), 32'd0);
      chk("rstacc wen_after", 32'(ram_wen), 32'd0);
      chk("rstacc state", 32'(dut.state), 32'(IDLE));
      chk("rstacc mem7", mem[7], 32'hDEADBEEF);
      step();
      @(negedge clk);
      chk("rstacc m0_ack_late", 32'(m0_ack), 32'd0);

      // Reset in RESP: ack still visible, pending m0 request not granted
      step();
      m1_req = 1'b1; m1_addr = 22'd4; m1_wen = 4'h0;
      step();
      step();
      rst = 1'b1; m0_req = 1'b1; m0_addr = 22'd9; m0_wen = 4'hF;
      @(negedge clk);
      chk("rstresp m1_ack", 32'(m1_ack), 32'd1);
      chk("rstresp m1_rdata", m1_rdata, 32'hFFFFFFFF);
      step();
      rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
      @(negedge clk);
      chk("rstresp state", 32'(dut.state), 32'(IDLE));
      chk("rstresp ram_wen", 32'(ram_wen), 32'd0);

      // Single-master stream: three word writes, one access per 3 cycles
      for (int c = 0; c < 10; c++) begin
         step();
         m0_req   = (c < 9);
         m0_addr  = 22'(c / 3);
         m0_wen   = 4'hF;
         m0_wdata = 32'hC0DE0000 + 32'(c / 3);
         @(negedge clk);
         chk($sformatf("stream c%0d ram_wen", c), 32'(ram_wen), (c % 3 == 1) ? 32'hF : 32'h0);
         chk($sformatf("stream c%0d m0_ack", c), 32'(m0_ack), (c % 3 == 2) ? 32'd1 : 32'd0);
         chk($sformatf("stream c%0d m1_ack", c), 32'(m1_ack), 32'd0);
      end
      chk("stream mem0", mem[0], 32'hC0DE0000);
      chk("stream mem1", mem[1], 32'hC0DE0001);
      chk("stream mem2", mem[2], 32'hC0DE0002);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter sharing the single-port, byte-write-enabled data RAM between the CPU data port (m0) and a second bus master (m1, loader/DMA). It takes word-addressed read/write requests on two req/ack channels and grants them round-robin. Each granted access is driven onto registered RAM control outputs, and the read word is returned with a one-cycle acknowledge pulse. It sits between `cpu`/loader and `ram`, replacing the direct CPU-to-RAM connection.

## Interface
- `ADDR_W`, default 22: word-address width, matching `ram.addr`.
- `DATA_W`, default 32: data word width.
- `clk` in, 1: single clock; all state changes on the rising edge.
- `rst` in, 1: reset, synchronous and active-high.
- `m0_req` in, 1: m0 request; addr, wdata and wen are held stable until `m0_ack`.
- `m0_addr` in, ADDR_W: m0 word address.
- `m0_wdata` in, DATA_W: m0 write data.
- `m0_wen` in, 4: m0 byte-lane write enables; 0 means a read.
- `m0_ack` out, 1: one-cycle completion pulse for m0.
- `m0_rdata` out, DATA_W: RAM word, valid only while `m0_ack` is high; 0 otherwise.
- `m1_req`, `m1_addr`, `m1_wdata`, `m1_wen`, `m1_ack`, `m1_rdata`: same as the m0 signals, for requester m1.
- `ram_wen` out, 4: RAM byte write enables (registered).
- `ram_addr` out, ADDR_W: RAM word address (registered).
- `ram_wdata` out, DATA_W: RAM write data (registered).
- `ram_rdata` in, DATA_W: RAM read word, registered inside the RAM with one-cycle latency.

## Operation
- FSM states are IDLE, ACCESS and RESP. A `gnt` register (0 = m0, 1 = m1) records the owner of the current access. A `last` register records the last requester served.
- **IDLE**:
  - If no request is present, stay in IDLE.
  - If exactly one requester has `req` high, grant it.
  - If both have `req` high, grant the one that is not `last`.
  - On a grant, load `ram_addr`, `ram_wdata` and `ram_wen` from the granted channel, set `gnt`, and go to ACCESS.
- **ACCESS**: the RAM outputs are valid for exactly this cycle, and the RAM samples them at the closing edge. Always go to RESP and clear `ram_wen` to 0.
- **RESP**:
  - Assert `mX_ack` for X = `gnt`, with `mX_rdata` = `ram_rdata` (combinational). For a write this returns the pre-write word, which the requester ignores. Set `last` = `gnt`.
  - In this cycle only the other requester's `req` is considered, because the acked requester still holds its `req`.
  - If the other requester's `req` is high, grant it (load the RAM registers) and go directly to ACCESS. Otherwise go to IDLE.
- `ram_wen` is nonzero only in ACCESS. `ram_addr` and `ram_wdata` hold their last values in the other states.
- `req` is sampled only in IDLE and RESP. A request withdrawn after its grant still completes and is acked.
- Addresses are word addresses passed through unmodified. Byte and halfword lane selection is the requester's job.
- Reset values:
  - state = IDLE
  - `last` = 1, so m0 wins the first tie
  - `ram_wen` = 0, `ram_addr` = 0, `ram_wdata` = 0
  - both acks = 0, both rdata = 0

## Timing
- A request first seen in IDLE in cycle T drives the RAM in cycle T+1 and is acked in cycle T+2.
- With both requesters continuously active, the grants alternate and an ack occurs every 2 cycles, with no IDLE cycle between accesses.
- A single requester re-requesting immediately after its ack (new request from T+3) is acked at T+5. Single-master throughput is therefore one access per 3 cycles.
- Reset asserted in ACCESS:
  - The RAM still samples that cycle's `ram_wen` at the same edge, so a write commits.
  - No ack is issued for that access.
  - The next cycle is IDLE with `ram_wen` = 0.
- Reset asserted in RESP suppresses any new grant. The ack is combinational on state, so it is still visible in that cycle.

## Structure
- Package `ram_arbiter_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP)
  - `ADDR_W`/`DATA_W` defaults
  - a `WEN_W` = 4 constant
- Sub-module `rr_arb2`: a combinational two-input round-robin picker taking `req[1:0]`, `last` and a `mask` input used in RESP, producing `valid` and `sel`.
- Datapath registers, FSM and ack/rdata muxing stay in `ram_arbiter`.

## Test plan
- **Reset**: hold `rst` for 2 cycles while both `req` are high.
  - During reset: `ram_wen` = 0, `ram_addr` = 0, both acks 0.
  - After release: m0 is granted first.
- **m0 halfword write**: addr 5, wdata 0x11223344, wen 4'b0011, request seen at T.
  - `ram_wen` = 0011 at T+1, `m0_ack` at T+2.
  - `mem[5]` changes from 0xFFFFFFFF to 0xFFFF3344.
- **m1 read**: `mem[5]` = 0x90A0B0C0, m1 reads addr 5.
  - `m1_ack` at T+2 with `m1_rdata` = 0x90A0B0C0.
  - `m0_rdata` = 0 throughout.
- **Continuous contention**: both requesters active after reset.
  - Ack order m0, m1, m0, m1 at cycles T+2, T+4, T+6, T+8.
  - Every access hits its own address correctly.
- **Reset during write**: `rst` asserted in the ACCESS cycle of an m0 write 0xDEADBEEF to addr 7.
  - `mem[7]` = 0xDEADBEEF.
  - `m0_ack` never pulses.
  - State is IDLE next cycle.
- **Single-master stream**: m0 issues 3 back-to-back word writes to addr 0, 1, 2 with m1 idle.
  - Acks at T+2, T+5, T+8.
  - `ram_wen` = 1111 only in cycles T+1, T+4, T+7.
